// File: rtl/stream_intf_pkg.sv
// Shared types and default sizing for the Mage PEA streaming buffer.
// Optional stall counters are enabled with the MAGE_STREAM_PERF_EN macro.
package stream_intf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } mage_stream_state_e;

  typedef enum logic {
    CH_IN  = 1'b0,  // DMA -> PEA
    CH_OUT = 1'b1   // PEA -> DMA
  } mage_ch_dir_e;

  localparam int unsigned MAGE_N_CH    = 4;
  localparam int unsigned MAGE_DATA_W  = 32;
  localparam int unsigned MAGE_DEPTH   = 4;
  localparam int unsigned MAGE_CNT_W   = 16;
  localparam int unsigned MAGE_STALL_W = 32;

endpackage

// File: rtl/mage_sync_fifo.sv
// Registered single-clock FIFO (no fall-through) with synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mage_sync_fifo
  import stream_intf_pkg::*;
#(
  parameter int unsigned DATA_W = MAGE_DATA_W,
  parameter int unsigned DEPTH  = MAGE_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers define validity and consumers mask data when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mage_stream_ctrl.sv
// Run-controlled DMA <-> PEA streaming buffer: per-channel FIFO, length counter and role mux.
// Define MAGE_STREAM_PERF_EN to build the per-channel sink stall counters.
module mage_stream_ctrl
  import stream_intf_pkg::*;
#(
  parameter int unsigned N_CH   = MAGE_N_CH,
  parameter int unsigned DATA_W = MAGE_DATA_W,
  parameter int unsigned DEPTH  = MAGE_DEPTH,
  parameter int unsigned CNT_W  = MAGE_CNT_W
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                start_i,
  input  logic                                abort_i,
  input  logic [N_CH-1:0]                     cfg_en_i,
  input  logic [N_CH-1:0]                     cfg_dir_i,
  input  logic [N_CH-1:0][CNT_W-1:0]          cfg_len_i,
  input  logic [N_CH-1:0]                     dma_valid_i,
  input  logic [N_CH-1:0][DATA_W-1:0]         dma_data_i,
  output logic [N_CH-1:0]                     dma_ready_o,
  output logic [N_CH-1:0]                     dma_valid_o,
  output logic [N_CH-1:0][DATA_W-1:0]         dma_data_o,
  input  logic [N_CH-1:0]                     dma_ready_i,
  input  logic [N_CH-1:0]                     pea_valid_i,
  input  logic [N_CH-1:0][DATA_W-1:0]         pea_data_i,
  output logic [N_CH-1:0]                     pea_ready_o,
  output logic [N_CH-1:0]                     pea_valid_o,
  output logic [N_CH-1:0][DATA_W-1:0]         pea_data_o,
  input  logic [N_CH-1:0]                     pea_ready_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [N_CH-1:0][MAGE_STALL_W-1:0]   perf_stall_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mage_stream_state_e state_q, state_d;

  logic [N_CH-1:0]             en_q;
  mage_ch_dir_e                dir_q [N_CH];
  logic [N_CH-1:0][CNT_W-1:0]  len_q, acc_q;

  logic                        start_acc, all_done, flush;
  logic [N_CH-1:0]             src_ready, src_valid, sink_valid, sink_ready;
  logic [N_CH-1:0]             push, pop, fifo_full, fifo_empty, ch_done;
  logic [N_CH-1:0][DATA_W-1:0] fifo_din, fifo_dout;

  assign start_acc = (state_q == IDLE) && start_i && !abort_i;
  assign flush     = (state_q == FLUSH);
  assign all_done  = &ch_done;
  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: next-state gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = RUN;
        RUN:     if (all_done) state_d = DONE;
        DONE:    state_d = IDLE;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Configuration is sampled only on an accepted start; inputs are free to change afterwards.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q  <= '0;
      len_q <= '0;
      for (int c = 0; c < N_CH; c++) dir_q[c] <= CH_IN;
    end else if (start_acc) begin
      en_q  <= cfg_en_i;
      len_q <= cfg_len_i;
      for (int c = 0; c < N_CH; c++) dir_q[c] <= mage_ch_dir_e'(cfg_dir_i[c]);
    end
  end

  // Source pushes are gated by acc_q < len_q, so the counter saturates at len without a compare here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (start_acc || flush) acc_q[c] <= '0;
        else if (push[c])       acc_q[c] <= acc_q[c] + CNT_ONE;
      end
    end
  end

  always_comb begin
    src_ready   = '0;
    src_valid   = '0;
    sink_valid  = '0;
    sink_ready  = '0;
    push        = '0;
    pop         = '0;
    ch_done     = '0;
    fifo_din    = '0;
    dma_ready_o = '0;
    dma_valid_o = '0;
    dma_data_o  = '0;
    pea_ready_o = '0;
    pea_valid_o = '0;
    pea_data_o  = '0;
    for (int c = 0; c < N_CH; c++) begin
      sink_valid[c] = !fifo_empty[c];
      src_ready[c]  = (state_q == RUN) && en_q[c] && !fifo_full[c] && (acc_q[c] < len_q[c]);
      ch_done[c]    = !en_q[c] || ((acc_q[c] == len_q[c]) && fifo_empty[c]);
      if (dir_q[c] == CH_OUT) begin
        src_valid[c]   = pea_valid_i[c];
        fifo_din[c]    = pea_data_i[c];
        sink_ready[c]  = dma_ready_i[c];
        pea_ready_o[c] = src_ready[c];
        dma_valid_o[c] = sink_valid[c];
        dma_data_o[c]  = sink_valid[c] ? fifo_dout[c] : '0;
      end else begin
        src_valid[c]   = dma_valid_i[c];
        fifo_din[c]    = dma_data_i[c];
        sink_ready[c]  = pea_ready_i[c];
        dma_ready_o[c] = src_ready[c];
        pea_valid_o[c] = sink_valid[c];
        pea_data_o[c]  = sink_valid[c] ? fifo_dout[c] : '0;
      end
      push[c] = src_valid[c] && src_ready[c];
      pop[c]  = sink_valid[c] && sink_ready[c];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    mage_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .flush (flush),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (fifo_din[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c]),
      .dout  (fifo_dout[c])
    );
  end

`ifdef MAGE_STREAM_PERF_EN
  logic [N_CH-1:0][MAGE_STALL_W-1:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (start_acc || flush) begin
          stall_q[c] <= '0;
        end else if ((state_q == RUN) && sink_valid[c] && !sink_ready[c] && (stall_q[c] != '1)) begin
          stall_q[c] <= stall_q[c] + {{(MAGE_STALL_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign perf_stall_o = stall_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_mage_stream_ctrl.sv
// Directed bench for mage_stream_ctrl: table-driven input-channel run plus hand-written
// sequences for backpressure, empty start, abort, async reset and stall counting.
module tb_mage_stream_ctrl;

  logic                  clk, rst_n;
  logic                  start, abort;
  logic [3:0]            cfg_en, cfg_dir;
  logic [3:0][15:0]      cfg_len;
  logic [3:0]            dma_valid_i, dma_ready_o, dma_valid_o, dma_ready_i;
  logic [3:0][31:0]      dma_data_i, dma_data_o;
  logic [3:0]            pea_valid_i, pea_ready_o, pea_valid_o, pea_ready_i;
  logic [3:0][31:0]      pea_data_i, pea_data_o;
  logic                  busy, done;
  logic [3:0][31:0]      perf_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  mage_stream_ctrl #(
    .N_CH(4), .DATA_W(32), .DEPTH(4), .CNT_W(16)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .cfg_en_i     (cfg_en),
    .cfg_dir_i    (cfg_dir),
    .cfg_len_i    (cfg_len),
    .dma_valid_i  (dma_valid_i),
    .dma_data_i   (dma_data_i),
    .dma_ready_o  (dma_ready_o),
    .dma_valid_o  (dma_valid_o),
    .dma_data_o   (dma_data_o),
    .dma_ready_i  (dma_ready_i),
    .pea_valid_i  (pea_valid_i),
    .pea_data_i   (pea_data_i),
    .pea_ready_o  (pea_ready_o),
    .pea_valid_o  (pea_valid_o),
    .pea_data_o   (pea_data_o),
    .pea_ready_i  (pea_ready_i),
    .busy_o       (busy),
    .done_o       (done),
    .perf_stall_o (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        dv;
    logic [31:0] dd;
    logic        pr;
    logic        e_dr;
    logic        e_pv;
    logic [31:0] e_pd;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic st, input logic dv, input logic [31:0] dd,
                              input logic pr, input logic e_dr, input logic e_pv,
                              input logic [31:0] e_pd, input logic e_busy, input logic e_done);
    vec_t v;
    v.start = st; v.dv = dv; v.dd = dd; v.pr = pr;
    v.e_dr = e_dr; v.e_pv = e_pv; v.e_pd = e_pd; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1'b1;
      else      tick();
    end
    check(name, 64'(seen), 64'd1);
    tick();
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; cfg_en = '0; cfg_dir = '0; cfg_len = '0;
    dma_valid_i = '0; dma_data_i = '0; dma_ready_i = '0;
    pea_valid_i = '0; pea_data_i = '0; pea_ready_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          sent, rcv, xfer;
    logic        done_seen;
    logic [31:0] last;
    logic [31:0] exp_stall;

    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy",       64'(busy), 0);
    check("rst done",       64'(done), 0);
    check("rst readys",     64'({dma_ready_o, pea_ready_o}), 0);
    check("rst valids",     64'({dma_valid_o, pea_valid_o}), 0);
    check("rst data",       64'(|{dma_data_o, pea_data_o}), 0);
    check("rst perf_stall", 64'(|perf_stall), 0);
    rst_n = 1;
    tick();

    // Input channel 0, three words, sink always ready.
    vecs[0] = mk(1, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    vecs[1] = mk(0, 1, 32'hA, 1, 1, 0, 32'h0, 1, 0);
    vecs[2] = mk(0, 1, 32'hB, 1, 1, 1, 32'hA, 1, 0);
    vecs[3] = mk(0, 1, 32'hC, 1, 1, 1, 32'hB, 1, 0);
    vecs[4] = mk(0, 1, 32'hD, 1, 0, 1, 32'hC, 1, 0);
    vecs[5] = mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
    vecs[6] = mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 1);
    vecs[7] = mk(0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    cfg_en = 4'b0001; cfg_dir = 4'b0000; cfg_len[0] = 16'd3;
    for (int i = 0; i < 8; i++) begin
      start          = vecs[i].start;
      dma_valid_i[0] = vecs[i].dv;
      dma_data_i[0]  = vecs[i].dd;
      pea_ready_i[0] = vecs[i].pr;
      check($sformatf("t1[%0d] dma_ready0", i), 64'(dma_ready_o[0]), 64'(vecs[i].e_dr));
      check($sformatf("t1[%0d] pea_valid0", i), 64'(pea_valid_o[0]), 64'(vecs[i].e_pv));
      check($sformatf("t1[%0d] pea_data0",  i), 64'(pea_data_o[0]),  64'(vecs[i].e_pd));
      check($sformatf("t1[%0d] busy",       i), 64'(busy),           64'(vecs[i].e_busy));
      check($sformatf("t1[%0d] done",       i), 64'(done),           64'(vecs[i].e_done));
      tick();
    end
    clear_inputs();

    // Output channel 1, eight words, DMA sink stalled until the FIFO fills.
    cfg_en = 4'b0010; cfg_dir = 4'b0010; cfg_len[1] = 16'd8;
    start = 1; tick(); start = 0;
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      pea_valid_i[1] = 1;
      pea_data_i[1]  = 32'h100 + sent;
      if (pea_ready_o[1]) sent++;
      tick();
    end
    check("t2 words before full", 64'(sent), 64'd4);
    check("t2 pea_ready1 full",   64'(pea_ready_o[1]), 0);
    check("t2 dma_valid1",        64'(dma_valid_o[1]), 1);
    check("t2 dma_data1 head",    64'(dma_data_o[1]), 64'h100);
    dma_ready_i[1] = 1;
    rcv = 0;
    done_seen = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (done) done_seen = 1;
      pea_data_i[1] = 32'h100 + sent;
      if (pea_ready_o[1]) sent++;
      if (dma_valid_o[1]) begin
        check($sformatf("t2 word %0d", rcv), 64'(dma_data_o[1]), 64'(32'h100 + rcv));
        rcv++;
      end
      tick();
    end
    check("t2 done seen",     64'(done_seen), 1);
    check("t2 words drained", 64'(rcv), 64'd8);
    check("t2 words accepted", 64'(sent), 64'd8);
    clear_inputs();

    // Empty enable mask: one RUN cycle, then DONE.
    start = 1;
    check("t3 busy idle", 64'(busy), 0);
    tick(); start = 0;
    check("t3 busy run",  64'(busy), 1);
    check("t3 done run",  64'(done), 0);
    tick();
    check("t3 busy done", 64'(busy), 0);
    check("t3 done done", 64'(done), 1);
    tick();
    check("t3 done idle", 64'(done), 0);

    // Abort with two words buffered, then a fresh single-word run.
    cfg_en = 4'b0001; cfg_dir = 4'b0000; cfg_len[0] = 16'd5;
    start = 1; tick(); start = 0;
    dma_valid_i[0] = 1; dma_data_i[0] = 32'h55; tick();
    dma_data_i[0] = 32'h66; tick();
    dma_valid_i[0] = 0;
    check("t4 buffered valid", 64'(pea_valid_o[0]), 1);
    check("t4 buffered head",  64'(pea_data_o[0]), 64'h55);
    abort = 1; tick(); abort = 0;
    check("t4 flush busy", 64'(busy), 0);
    check("t4 flush done", 64'(done), 0);
    tick();
    check("t4 idle valids", 64'({dma_valid_o, pea_valid_o}), 0);
    check("t4 idle readys", 64'({dma_ready_o, pea_ready_o}), 0);
    cfg_len[0] = 16'd1; pea_ready_i[0] = 1;
    start = 1; tick(); start = 0;
    dma_valid_i[0] = 1; dma_data_i[0] = 32'h77;
    xfer = 0; last = '0; done_seen = 0;
    for (int i = 0; i < 12 && !done_seen; i++) begin
      if (done) done_seen = 1;
      if (pea_valid_o[0]) begin
        xfer++;
        last = pea_data_o[0];
      end
      tick();
    end
    check("t4 done seen",      64'(done_seen), 1);
    check("t4 words after abort", 64'(xfer), 64'd1);
    check("t4 word value",     64'(last), 64'h77);
    check("t4 ready after",    64'(dma_ready_o[0]), 0);
    clear_inputs();

    // Asynchronous reset in the middle of a cycle with data buffered.
    cfg_en = 4'b0001; cfg_dir = 4'b0000; cfg_len[0] = 16'd4;
    start = 1; tick(); start = 0;
    dma_valid_i[0] = 1; dma_data_i[0] = 32'h11; tick();
    dma_data_i[0] = 32'h22; tick();
    dma_valid_i[0] = 0;
    check("t5 pre-reset valid", 64'(pea_valid_o[0]), 1);
    #2 rst_n = 0;
    #1;
    check("t5 async valid",  64'(pea_valid_o[0]), 0);
    check("t5 async ready",  64'(dma_ready_o[0]), 0);
    check("t5 async data",   64'(pea_data_o[0]), 0);
    check("t5 async busy",   64'(busy), 0);
    tick();
    rst_n = 1;
    tick();
    check("t5 empty after release", 64'(pea_valid_o[0]), 0);
    check("t5 idle after release",  64'(busy), 0);
    clear_inputs();

    // Sink stall counting: five RUN cycles of valid with ready low.
`ifdef MAGE_STREAM_PERF_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    cfg_en = 4'b0001; cfg_dir = 4'b0000; cfg_len[0] = 16'd1;
    start = 1; tick(); start = 0;
    dma_valid_i[0] = 1; dma_data_i[0] = 32'h99; tick();
    dma_valid_i[0] = 0;
    repeat (5) tick();
    check("t6 perf_stall0", 64'(perf_stall[0]), 64'(exp_stall));
    check("t6 perf_stall1", 64'(perf_stall[1]), 0);
    pea_ready_i[0] = 1;
    wait_done("t6 done seen", 10);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mage_stream_ctrl.md
# mage_stream_ctrl

Parametrised, run-controlled streaming buffer between the DMA hardware-FIFO channels and the Mage processing element array (PEA). Each of `N_CH` channels is configured as input (DMA→PEA) or output (PEA→DMA). Each channel has its own `DEPTH`-entry elastic FIFO and a transfer-length counter. A run-control FSM sequences a kernel: start, stream exactly `cfg_len` words per enabled channel, signal done. It replaces the fixed, always-on channel wiring of the current streaming interface.

## Interface
- `N_CH`, 4: number of DMA channels.
- `DATA_W`, 32: word width.
- `DEPTH`, 4: FIFO entries per channel; must be a power of 2, ≥2.
- `CNT_W`, 16: transfer-length counter width.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  start pulse; honoured only in IDLE.
- `abort_i`  in  1  abort pulse; honoured in any state.
- `cfg_en_i`  in  N_CH  channel enable mask.
- `cfg_dir_i`  in  N_CH  per channel: 1 = output (PEA→DMA), 0 = input.
- `cfg_len_i`  in  N_CH×CNT_W  words to transfer per channel.
- `dma_valid_i`, `dma_data_i`, `dma_ready_o`  in/in/out  N_CH / N_CH×DATA_W / N_CH  DMA source side (input channels).
- `dma_valid_o`, `dma_data_o`, `dma_ready_i`  out/out/in  DMA sink side (output channels).
- `pea_valid_i`, `pea_data_i`, `pea_ready_o`  in/in/out  PEA source side (output channels).
- `pea_valid_o`, `pea_data_o`, `pea_ready_i`  out/out/in  PEA sink side (input channels).
- `busy_o`  out  1  FSM in RUN.
- `done_o`  out  1  one-cycle completion pulse.
- `perf_stall_o`  out  N_CH×32  per-channel sink stall count.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on `start_i`. The channel configuration is latched on the same edge.
  - RUN→DONE when every enabled channel is complete.
  - DONE→IDLE unconditionally after 1 cycle.
  - Any state→FLUSH on `abort_i`. FLUSH→IDLE after 1 cycle.
- Role mapping: an input channel uses DMA as source and PEA as sink; an output channel uses PEA as source and DMA as sink. Unused-side outputs are held at 0.
- A transfer occurs when valid && ready on the same cycle.
- Source ready = RUN && enabled && !full && acc_cnt < len.
- Sink valid = !empty. Sink data = FIFO head; it is held stable while valid && !ready.
- `acc_cnt` increments on each source transfer. It is cleared on entry to RUN and in FLUSH.
- Channel complete = !enabled, or (acc_cnt == len && empty). `len` = 0 means complete immediately.
- A start with no channels enabled goes RUN→DONE after one RUN cycle.
- FLUSH clears all FIFO pointers, counters and stall counters; buffered data is discarded.
- `start_i` outside IDLE is ignored. `abort_i` takes priority over `start_i` and over completion in the same cycle.
- Configuration inputs are don't-care outside the start edge; the latched copies are used.

## Timing
- Reset values: all valid/ready outputs 0, all data outputs 0, `busy_o` 0, `done_o` 0, `perf_stall_o` 0, state IDLE, FIFOs empty.
- FIFO is registered, with no fall-through. A word pushed in cycle t is visible on the sink in cycle t+1.
- Full FIFO: source ready is 0 even if a pop occurs in the same cycle. Simultaneous push and pop on a non-full, non-empty FIFO is supported; occupancy is unchanged.
- Pointers are log2(DEPTH) bits plus 1 wrap bit. Full = same index with differing wrap bit.
- `busy_o` rises the cycle after `start_i`.
- `done_o` is high for exactly the cycle in DONE. This is the cycle after the last channel's FIFO drains.
- `acc_cnt` saturates at `len`; no wrap-around.
- Reset asserted mid-run returns all state to reset values immediately, because reset is asynchronous.

## Configuration
- Macro: `MAGE_STREAM_PERF_EN`.
- Defined:
  - A 32-bit counter per channel increments each RUN cycle with sink valid && !ready.
  - The counter saturates at 2^32−1.
  - It is cleared on start and in FLUSH.
  - The value drives `perf_stall_o`.
- Undefined: no counters are instantiated and `perf_stall_o` is tied to 0.

## Structure
- `stream_intf_pkg` holds:
  - the `mage_stream_state_e` enum (IDLE/RUN/FLUSH/DONE);
  - the `mage_ch_dir_e` enum (CH_IN/CH_OUT);
  - the default `N_CH`, `DATA_W`, `DEPTH` and `CNT_W` constants.
- Sub-module `mage_sync_fifo`: parametrised `DATA_W`/`DEPTH` FIFO with push, pop, full, empty and flush, generated `N_CH` times.
- FSM, counters and role muxing live in `mage_stream_ctrl`.

## Test plan
- Ch0 input, len=3, DMA pushes 0xA,0xB,0xC, `pea_ready_i`=1 → `pea_data_o` shows A,B,C on consecutive cycles, each 1 cycle after acceptance. `done_o` pulses once. `dma_ready_o[0]` stays 0 after the 3rd word.
- Ch1 output, len=8, DEPTH=4, `dma_ready_i`=0 → `pea_ready_o[1]` drops after 4 words. Releasing `dma_ready_i` drains 8 words in order, then `done_o`.
- `cfg_en`=0 with `start_i` → `busy_o` high 1 cycle, `done_o` next cycle.
- Abort during RUN with 2 words buffered → FLUSH then IDLE. All valids 0. A new start with len=1 transfers exactly 1 word.
- `rst_n_i` low mid-transfer → all outputs 0 asynchronously and the FIFOs are empty after release.
- With `MAGE_STREAM_PERF_EN`: hold `pea_ready_i`=0 for 5 RUN cycles with valid high → `perf_stall_o[0]`=5. Without the macro → 0.
